instr_fetch_assembler: RTL
==========================

Name: instr_fetch_assembler

Overview:
- Consumer side of the program counter's address interface.
- Drives update_lsbs and update_msbs to walk the PC through the 4 bytes of each instruction, and captures the byte-wide synchronous instruction memory.
- Assembles each 32-bit big-endian MIPS instruction and presents it to the decoder on a valid/ready handshake.
- Sits between program_counter/instruction memory and the decode stage; squashes in-flight fetches when the decoder redirects the PC with jump or brancher.

Parameters:
- INSTR_BYTES, 4, bytes per instruction. Only 4 is supported; it matches the PC's 2 byte-offset bits.
- MEM_RD_LAT, 1, instruction memory read latency in cycles. Only 1 is supported: data for the address in cycle N is valid in cycle N+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- fetch_en  in  1  allows a new instruction fetch to start.
- mem_addr  in  8  current PC byte address, from program_counter.
- mem_rdata  in  8  instruction memory read data, 1-cycle latency.
- update_lsbs  out  1  to program_counter: advance byte offset.
- update_msbs  out  1  to program_counter: advance to next instruction, offset cleared.
- redirect  in  1  high in the cycle the decoder drives jump or brancher to program_counter.
- instr  out  32  assembled instruction; byte at offset 0 goes to [31:24].
- instr_pc  out  6  instruction index (mem_addr[7:2]) of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decoder accepts; transfer when valid && ready.

Behaviour:
- Reset (rst_n==0 at a rising edge):
  - state=PRIME, cnt=0, staging=0.
  - instr=0, instr_pc=0, instr_valid=0.
  - update_lsbs/update_msbs are forced 0 combinationally while rst_n==0.
  - Reset mid-fetch discards all partial data.
- States: PRIME, CAP, LAST, STALL. The 2-bit counter cnt is used in CAP.
- PRIME:
  - If fetch_en && !redirect: update_lsbs=1, latch pc_q=mem_addr[7:2], go to CAP with cnt=0.
  - Otherwise stay in PRIME with no update pulses.
- CAP:
  - staging byte[cnt] <= mem_rdata.
  - update_lsbs=1 when cnt<2.
  - At cnt==2 go to LAST; otherwise cnt++.
- LAST:
  - mem_rdata is byte 3.
  - Define slot_free = !instr_valid || instr_ready.
  - If slot_free: load instr/instr_pc/instr_valid=1 from staging+byte3, assert update_msbs=1, go to PRIME.
  - Else: store byte3 into staging, go to STALL.
- STALL:
  - Hold with update_msbs=0; mem_addr stays at offset 3.
  - When slot_free: load the output register from staging, assert update_msbs=1, go to PRIME.
- Timing, unstalled:
  - Update pattern per instruction is lsbs, lsbs, lsbs, –, msbs: 5 cycles per instruction.
  - instr_valid rises the cycle after LAST.
- Output handshake:
  - instr, instr_pc and instr_valid are registered and stable while valid && !ready.
  - On valid && ready with no new load in the same cycle, instr_valid <= 0.
  - A load in the same cycle as a transfer keeps valid=1 (back-to-back).
- redirect (any state):
  - update_lsbs=0 and update_msbs=0 combinationally that cycle, so the PC's priority lets jump/brancher take effect.
  - Next edge: state=PRIME, cnt=0, staging discarded, instr_valid=0.
  - A valid && ready in the redirect cycle still counts as accepted.
  - fetch_en is ignored until the following PRIME cycle.
- Mid-fetch control:
  - fetch_en deasserted after PRIME is ignored; the current instruction completes.
- Width and wrap rules:
  - instr_pc is 6 bits.
  - The PC wraps 0xFC→0x00 on update_msbs; nothing in this block special-cases the wrap.
- Never asserts update_lsbs and update_msbs in the same cycle.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding enum fetch_state_t (PRIME, CAP, LAST, STALL);
  - INSTR_BYTES=4;
  - OFFSET_W=2;
  - MIPS_NOP=32'h0000_0000.
- One natural sub-module, fetch_out_reg: the valid/ready output holding register with load, accept and flush inputs.
- The FSM and byte staging stay in the top module.

Test Plan:
- Basic fetch: reset release, fetch_en=1, ready=1, mem[0..3]=12 34 56 78, mem[4..7]=AA BB CC DD.
  - update_lsbs high in cycles 0-2 and update_msbs in cycle 4.
  - instr=0x12345678, instr_pc=0 valid in cycle 5.
  - instr=0xAABBCCDD, instr_pc=1 valid in cycle 10.
- Backpressure: ready=0 from cycle 5.
  - Second instruction enters STALL, mem_addr holds 0x07, no update_msbs.
  - Raise ready in cycle 14: first instruction transfers, second loads in the same cycle, update_msbs pulses once, mem_addr=0x08 next cycle.
- Redirect during CAP cnt=1, with jump_destination=0x10 at the PC:
  - No update pulses in that cycle.
  - mem_addr=0x40 next cycle; partial instruction never appears.
  - Next instr_pc=0x10.
- Idle: fetch_en=0 in PRIME for 10 cycles.
  - update_lsbs/update_msbs stay 0 and mem_addr is constant.
  - Raising fetch_en starts a fetch the same cycle.
- Reset mid-operation: rst_n=0 for one edge during CAP.
  - instr_valid=0, state=PRIME, updates gated while low.
  - After release the fetch restarts from PC 0x00.
- Wrap: fetch at mem_addr 0xFC (mem=01 02 03 04).
  - instr=0x01020304, instr_pc=0x3F.
  - update_msbs brings mem_addr to 0x00, and the next fetch has instr_pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
// State encoding, byte geometry and the NOP reset word.
package fetch_pkg;

  typedef enum logic [1:0] {
    PRIME,
    CAP,
    LAST,
    STALL
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam int OFFSET_W = 2;
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready holding register for one assembled instruction.
// Ports: clk, rst_n, load/flush/accept controls, load data, instr outputs.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        accept,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [5:0]  load_pc,
  output logic [31:0] instr,
  output logic [5:0]  instr_pc,
  output logic        instr_valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr       <= MIPS_NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= load_instr;
      instr_pc    <= load_pc;
      instr_valid <= 1'b1;
    end else if (accept) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_assembler.sv
// Walks the PC through each instruction's bytes and assembles them.
// Ports: clk, rst_n, fetch_en, mem_addr/mem_rdata, update_lsbs/msbs,
//        redirect, instr/instr_pc/instr_valid/instr_ready.
module instr_fetch_assembler
  import fetch_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic [7:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        update_lsbs,
  output logic        update_msbs,
  input  logic        redirect,
  output logic [31:0] instr,
  output logic [5:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int LAST_B = INSTR_BYTES - 1;
  // Byte captured when the final address is already on the bus.
  localparam logic [OFFSET_W-1:0] CAP_LAST =
    OFFSET_W'(INSTR_BYTES - 1 - MEM_RD_LAT);

  fetch_state_t state;
  logic [OFFSET_W-1:0] cnt;
  logic [INSTR_BYTES-1:0][7:0] staging;
  logic [5:0] pc_q;

  logic slot_free;
  logic accept;
  logic load;
  logic [31:0] load_instr;
  logic unused_offset;

  assign unused_offset = ^mem_addr[1:0];
  assign accept = instr_valid && instr_ready;
  assign slot_free = !instr_valid || instr_ready;

  always_comb begin
    update_lsbs = 1'b0;
    load = 1'b0;
    load_instr = {staging[0], staging[1],
                  staging[2], staging[LAST_B]};
    if (rst_n && !redirect) begin
      unique case (state)
        PRIME: update_lsbs = fetch_en;
        CAP:   update_lsbs = cnt < CAP_LAST;
        LAST: begin
          load = slot_free;
          load_instr = {staging[0], staging[1],
                        staging[2], mem_rdata};
        end
        STALL: load = slot_free;
        default: ;
      endcase
    end
    update_msbs = load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= PRIME;
      cnt     <= '0;
      staging <= '0;
      pc_q    <= '0;
    end else if (redirect) begin
      state   <= PRIME;
      cnt     <= '0;
      staging <= '0;
    end else begin
      unique case (state)
        PRIME: begin
          if (fetch_en) begin
            state <= CAP;
            cnt   <= '0;
            pc_q  <= mem_addr[7:2];
          end
        end
        CAP: begin
          staging[cnt] <= mem_rdata;
          if (cnt == CAP_LAST) state <= LAST;
          else cnt <= cnt + 1'b1;
        end
        LAST: begin
          if (slot_free) begin
            state <= PRIME;
          end else begin
            // Byte 3 is only on the bus this cycle.
            staging[LAST_B] <= mem_rdata;
            state <= STALL;
          end
        end
        STALL: begin
          if (slot_free) state <= PRIME;
        end
        default: state <= PRIME;
      endcase
    end
  end

  fetch_out_reg u_out (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .accept      (accept),
    .flush       (redirect),
    .load_instr  (load_instr),
    .load_pc     (pc_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

endmodule
